// File: rtl/display_scan_pkg.sv
// Shared types and constants for the elevator panel display scanner.
//   state_e    : scan FSM states
//   SEG_BLANK  : all segments off
//   DIG_*      : one-hot digit enables (floor / people / none)
//   SEG_LUT    : 0..7 -> active-high a..g pattern, dp always 0
package display_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BLANK_F,
    SHOW_F,
    BLANK_P,
    SHOW_P
  } state_e;

  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam logic [1:0] DIG_NONE   = 2'b00;
  localparam logic [1:0] DIG_FLOOR  = 2'b01;
  localparam logic [1:0] DIG_PEOPLE = 2'b10;

  // Element i holds the pattern for digit i (element 0 is rightmost).
  localparam logic [7:0][7:0] SEG_LUT = {
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/display_scan_ctrl_seg7_decoder.sv
// Combinational seven-segment decoder for values 0..7.
//   val   : 3-bit digit value
//   seg_c : active-high segment pattern, bit0=a .. bit6=g, bit7=dp (0)
module seg7_decoder
  import display_scan_pkg::*;
(
  input  logic [2:0] val,
  output logic [7:0] seg_c
);

  assign seg_c = SEG_LUT[val];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the shared floor/occupancy display.
// Each slot of TICK_DIV cycles starts with BLANK_CYC blank cycles; the
// occupancy digit blinks with a BLINK_SLOTS-slot half period when overloaded.
//   clk, rst : clock, asynchronous active-high reset
//   en       : scan enable, 0 returns to IDLE with a blank display
//   floor    : floor number 0..3, people : occupancy 0..7
//   seg, dig : registered segment pattern and one-hot digit enable
//   slot     : 0 = floor slot, 1 = people slot
//   overload : registered people_sh > MAX_PEOPLE
module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned BLINK_SLOTS = 64,
  parameter int unsigned MAX_PEOPLE  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] floor,
  input  logic [2:0] people,
  output logic [7:0] seg,
  output logic [1:0] dig,
  output logic       slot,
  output logic       overload
);

  localparam int unsigned CNT_W   = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_SLOTS + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         floor_sh_q, floor_sh_d;
  logic [2:0]         people_sh_q, people_sh_d;
  logic               overload_q, overload_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [BLINK_W-1:0] blink_inc;
  logic               blink_ph_q, blink_ph_d;
  logic [7:0]         seg_q, seg_d;
  logic [1:0]         dig_q, dig_d;
  logic               slot_q, slot_d;
  logic               sample;
  logic               p_slot_end;
  logic [2:0]         dec_val;
  logic [7:0]         dec_seg;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      floor_sh_q  <= '0;
      people_sh_q <= '0;
      overload_q  <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_q       <= SEG_BLANK;
      dig_q       <= DIG_NONE;
      slot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      floor_sh_q  <= floor_sh_d;
      people_sh_q <= people_sh_d;
      overload_q  <= overload_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      slot_q      <= slot_d;
    end
  end

  assign blink_inc = blink_cnt_q + BLINK_W'(1);

  // Next state, slot counter, input sampling and blink bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    floor_sh_d  = floor_sh_q;
    people_sh_d = people_sh_q;
    overload_d  = overload_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    sample      = 1'b0;
    p_slot_end  = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = BLANK_F;
        cnt_d   = '0;
        sample  = 1'b1;
      end
      BLANK_F: if (cnt_q == CNT_W'(BLANK_CYC - 1)) state_d = SHOW_F;
      SHOW_F: begin
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          state_d = BLANK_P;
          cnt_d   = '0;
          sample  = 1'b1;
        end
      end
      BLANK_P: if (cnt_q == CNT_W'(BLANK_CYC - 1)) state_d = SHOW_P;
      SHOW_P: begin
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          state_d    = BLANK_F;
          cnt_d      = '0;
          sample     = 1'b1;
          p_slot_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over every transition; shadows and overload are held.
    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sample     = 1'b0;
      p_slot_end = 1'b0;
    end

    if (sample) begin
      floor_sh_d  = floor;
      people_sh_d = people;
      overload_d  = 32'(people) > MAX_PEOPLE;
    end

    // Blink only counts people slots that were shown while overloaded.
    if (!en || (sample && !overload_d)) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (p_slot_end && overload_q) begin
      if (blink_inc == BLINK_W'(BLINK_SLOTS)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_inc;
      end
    end
  end

  // Single decoder shared by both digits; shadows are stable within a slot.
  assign dec_val = (state_d == SHOW_P) ? people_sh_d : {1'b0, floor_sh_d};

  seg7_decoder u_dec (
    .val   (dec_val),
    .seg_c (dec_seg)
  );

  // Moore outputs computed from the next state so they register with it.
  always_comb begin
    seg_d  = SEG_BLANK;
    dig_d  = DIG_NONE;
    slot_d = (state_d == BLANK_P) || (state_d == SHOW_P);
    case (state_d)
      SHOW_F: begin
        seg_d = dec_seg;
        dig_d = DIG_FLOOR;
      end
      SHOW_P: begin
        if (!(overload_d && blink_ph_d)) begin
          seg_d = dec_seg;
          dig_d = DIG_PEOPLE;
        end
      end
      default: ;
    endcase
  end

  assign seg      = seg_q;
  assign dig      = dig_q;
  assign slot     = slot_q;
  assign overload = overload_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: frame-position reference model,
// literal scenario checks and randomized stimulus with invariant checks.
module tb_display_scan_ctrl;

  localparam int unsigned TD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned BS = 2;
  localparam int unsigned MP = 5;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       en     = 1'b1;
  logic [1:0] floor  = 2'd3;
  logic [2:0] people = 3'd4;
  logic [7:0] seg;
  logic [1:0] dig;
  logic       slot;
  logic       overload;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  display_scan_ctrl #(
    .TICK_DIV    (TD),
    .BLANK_CYC   (BC),
    .BLINK_SLOTS (BS),
    .MAX_PEOPLE  (MP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .floor    (floor),
    .people   (people),
    .seg      (seg),
    .dig      (dig),
    .slot     (slot),
    .overload (overload)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int v);
    case (v)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      default: return 8'h07;
    endcase
  endfunction

  // Reference model: position within a 2*TD frame plus sampled values.
  bit m_act;
  int m_pos;
  int m_fl;
  int m_pp;
  int m_bc;
  bit m_ov;
  bit m_ph;

  task automatic m_take(input bit end_of_p);
    bit old_ov;
    old_ov = m_ov;
    m_fl = int'(floor);
    m_pp = int'(people);
    m_ov = (m_pp > int'(MP));
    if (!m_ov) begin
      m_bc = 0;
      m_ph = 1'b0;
    end else if (end_of_p && old_ov) begin
      m_bc++;
      if (m_bc == int'(BS)) begin
        m_bc = 0;
        m_ph = !m_ph;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit endp;
    if (rst) begin
      m_act = 1'b0; m_pos = 0; m_fl = 0; m_pp = 0;
      m_bc = 0; m_ov = 1'b0; m_ph = 1'b0;
    end else if (!en) begin
      m_act = 1'b0; m_pos = 0; m_bc = 0; m_ph = 1'b0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_pos = 0;
      m_take(1'b0);
    end else begin
      endp  = (m_pos == int'(2 * TD) - 1);
      m_pos = (m_pos + 1) % int'(2 * TD);
      if (m_pos == 0 || m_pos == int'(TD)) m_take(endp);
    end
  end

  task automatic model_out(output logic [7:0] es, output logic [1:0] ed, output logic esl);
    int w;
    es  = 8'h00;
    ed  = 2'b00;
    esl = 1'b0;
    if (m_act) begin
      esl = (m_pos >= int'(TD));
      w   = m_pos % int'(TD);
      if (w >= int'(BC)) begin
        if (!esl) begin
          es = ref_seg(m_fl);
          ed = 2'b01;
        end else if (!(m_ov && m_ph)) begin
          es = ref_seg(m_pp);
          ed = 2'b10;
        end
      end
    end
  endtask

  // Per-cycle compare against the model plus display invariants.
  logic [1:0] last_nz = 2'b00;
  int         zrun    = 0;

  always @(negedge clk) begin : compare
    logic [7:0] es;
    logic [1:0] ed;
    logic       esl;
    if (chk_on) begin
      model_out(es, ed, esl);
      check("model_seg", seg, es);
      check("model_dig", 8'(dig), 8'(ed));
      check("model_slot", 8'(slot), 8'(esl));
      check("model_overload", 8'(overload), 8'(m_ov));
      check("dig_not_11", 8'(dig == 2'b11), 8'd0);
      if (dig == 2'b00) begin
        check("seg_blank_when_off", seg, 8'h00);
        zrun++;
      end else begin
        if (last_nz != 2'b00 && last_nz != dig)
          check("blank_gap", 8'(zrun >= int'(BC)), 8'd1);
        last_nz = dig;
        zrun    = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Literal frame for floor=3, people=4 right after leaving IDLE.
  task automatic check_frame();
    for (int i = 0; i < 16; i++) begin
      int w;
      @(negedge clk);
      w = i % 8;
      check("frame_slot", 8'(slot), 8'(i >= 8));
      if (w < 2) begin
        check("frame_dig_blank", 8'(dig), 8'd0);
        check("frame_seg_blank", seg, 8'h00);
      end else if (i < 8) begin
        check("frame_dig_floor", 8'(dig), 8'd1);
        check("frame_seg_floor", seg, 8'h4F);
      end else begin
        check("frame_dig_people", 8'(dig), 8'd2);
        check("frame_seg_people", seg, 8'h66);
      end
    end
  endtask

  initial begin
    logic [7:0] blink_seg [4];
    logic [1:0] blink_dig [4];
    blink_seg[0] = 8'h07; blink_seg[1] = 8'h00; blink_seg[2] = 8'h00; blink_seg[3] = 8'h07;
    blink_dig[0] = 2'b10; blink_dig[1] = 2'b00; blink_dig[2] = 2'b00; blink_dig[3] = 2'b10;

    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_seg", seg, 8'h00);
    check("rst_dig", 8'(dig), 8'd0);
    check("rst_slot", 8'(slot), 8'd0);
    check("rst_overload", 8'(overload), 8'd0);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_frame();                      // ends at frame position 15

    // Floor change mid SHOW_F is held until the next sample.
    wait_cyc(4);                        // position 3
    floor = 2'd1;
    for (int i = 4; i < 8; i++) begin
      wait_cyc(1);
      check("hold_floor_seg", seg, 8'h4F);
    end
    wait_cyc(11);                       // next frame position 2
    check("new_floor_seg", seg, 8'h06);
    check("new_floor_dig", 8'(dig), 8'd1);

    // Overload and blink.
    people = 3'd7;
    wait_cyc(6);                        // position 8: people sample
    check("overload_set", 8'(overload), 8'd1);
    wait_cyc(2);                        // position 10
    check("ovl_p0_seg", seg, 8'h07);
    check("ovl_p0_dig", 8'(dig), 8'd2);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(16);
      check("blink_seg", seg, blink_seg[k]);
      check("blink_dig", 8'(dig), 8'(blink_dig[k]));
    end
    people = 3'd3;
    wait_cyc(16);
    check("ovl_clear", 8'(overload), 8'd0);
    check("ovl_clear_seg", seg, 8'h4F);
    check("ovl_clear_dig", 8'(dig), 8'd2);

    // Disable mid SHOW_P, then re-enable with a fresh sample.
    wait_cyc(2);
    en = 1'b0;
    wait_cyc(1);
    check("dis_dig", 8'(dig), 8'd0);
    check("dis_seg", seg, 8'h00);
    check("dis_slot", 8'(slot), 8'd0);
    wait_cyc(3);
    people = 3'd7;
    en     = 1'b1;
    wait_cyc(1);
    check("reen_dig", 8'(dig), 8'd0);
    check("reen_overload", 8'(overload), 8'd1);
    wait_cyc(2);
    check("reen_show_dig", 8'(dig), 8'd1);
    check("reen_show_seg", seg, 8'h06);

    // Asynchronous reset between edges during SHOW_F.
    floor  = 2'd3;
    people = 3'd4;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_seg", seg, 8'h00);
    check("arst_dig", 8'(dig), 8'd0);
    check("arst_overload", 8'(overload), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    check_frame();

    // Randomized run; inputs held for stretches so blinking gets exercised.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) floor = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) people = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexing scheduler for the shared 8-bit seven-segment display of the elevator panel. It alternates the display between the floor digit and the occupancy digit using a programmable slot length. Each slot starts with a blanking interval to prevent ghosting. The occupancy digit blinks when the cabin is overloaded. It replaces raw clock-gated muxing with a clocked FSM that owns the display bus.

Parameters:
TICK_DIV, 8'd50 (scaled as required), clk cycles per slot including blanking; must be >= 2
BLANK_CYC, 2, blank cycles at the start of each slot; 1 <= BLANK_CYC < TICK_DIV
BLINK_SLOTS, 64, completed people-slots per blink half-period; must be >= 1
MAX_PEOPLE, 5, overload when occupancy > MAX_PEOPLE

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 forces IDLE and a blank display
floor  in  2  current floor number, 0-3
people  in  3  occupancy, 0-7
seg  out  8  segment pattern, active-high; bit0=a .. bit6=g, bit7=dp (always 0)
dig  out  2  one-hot digit enable; 01=floor digit, 10=people digit, 00=blank
slot  out  1  0=floor slot, 1=people slot
overload  out  1  registered flag, people_sh > MAX_PEOPLE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, cnt 0, seg 8'h00, dig 2'b00, slot 0, overload 0, floor_sh/people_sh 0, blink_cnt 0, blink_ph 0.
- All outputs are registered and updated on the same edge as the state (Moore). Reset clears them immediately, without waiting for a clock edge.
- FSM states: IDLE, BLANK_F, SHOW_F, BLANK_P, SHOW_P.
- Slot counter cnt runs 0..TICK_DIV-1 inside each slot and clears on every slot change.
- IDLE -> BLANK_F on the first edge with en=1.
- BLANK_x -> SHOW_x when cnt==BLANK_CYC-1.
- SHOW_F -> BLANK_P and SHOW_P -> BLANK_F when cnt==TICK_DIV-1.
- Frame period is 2*TICK_DIV cycles.
- Sampling: floor_sh and people_sh load on the edge that enters BLANK_F or BLANK_P. overload is updated on that same edge from the new people value. A digit's value never changes within a slot.
- Outputs per state:
  - IDLE/BLANK_x: dig=00, seg=00.
  - SHOW_F: dig=01, seg=dec(floor_sh).
  - SHOW_P: dig=10, seg=dec(people_sh).
  - slot=0 in BLANK_F/SHOW_F, slot=1 in BLANK_P/SHOW_P.
- Decode table (0..7): 3F, 06, 5B, 4F, 66, 6D, 7D, 07. floor is zero-extended to 3 bits.
- Blink:
  - While overload=1, SHOW_P is blanked (dig=00, seg=00) when blink_ph=1.
  - blink_cnt increments at the end of each SHOW_P. On reaching BLINK_SLOTS it clears and blink_ph toggles.
  - If overload samples as 0, blink_cnt and blink_ph clear on that edge.
  - The floor digit is never affected by blink.
- en=0 in any state: next edge goes to IDLE, clears cnt/blink state and blanks outputs. Shadows and overload are held. Re-enabling restarts at BLANK_F with a fresh sample.
- Invariants:
  - dig is never 11.
  - Every 01<->10 transition is separated by >= BLANK_CYC cycles of 00.

Decomposition:
- Package display_scan_pkg: state enum, SEG_BLANK=8'h00, DIG_NONE/DIG_FLOOR/DIG_PEOPLE constants, 8-entry decode constant array.
- Sub-module seg7_decoder: combinational, 3-bit value -> 8-bit pattern. Instantiated once, fed by a slot-muxed shadow value.

Test Plan (TICK_DIV=8, BLANK_CYC=2, BLINK_SLOTS=2, MAX_PEOPLE=5):
1. rst=1, en=1 -> seg=00, dig=00, slot=0. Release rst with floor=3, people=4 -> dig=00 for 2 cycles, then dig=01/seg=4F for 6, dig=00 for 2, dig=10/seg=66 for 6; repeats every 16 cycles.
2. Change floor 3->1 mid-SHOW_F -> seg stays 4F until the slot ends. Next SHOW_F shows 06.
3. people=7 -> overload=1 from the next slot boundary. SHOW_P pattern is seg=07/dig=10 for 2 slots, then dig=00 for 2 slots, repeating. Floor slots stay unchanged. people=3 -> overload=0 and normal display at the next sample.
4. en 1->0 mid-SHOW_P -> next edge dig=00, seg=00, IDLE. en->1 -> BLANK_F with cnt=0 and fresh sample.
5. Assert rst between clock edges during SHOW_F -> seg=00, dig=00, overload=0 immediately. Release -> same sequence as scenario 1.
6. Random floor/people/en for 10k cycles -> assertion: dig!=11, no direct 01<->10 transition, seg==00 whenever dig==00.
